// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Output-drive stage fed by the SPI register file. Takes the five
//   configuration bytes (output enables, PWM-mode selects, shared duty
//   value) from the SCLK domain and drives 16 user outputs. Each output is
//   static high/low or follows one shared 8-bit PWM waveform. The period is
//   PRESCALE*256 clocks.
//   Configuration is resynchronised into clk and latched into shadow
//   registers only at PWM period boundaries, so the outputs never glitch.
//
// Parameters
//   PRESCALE         system clocks per PWM count step (1..65535)
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   en_reg_out_7_0   output enables, outputs 7..0   (SCLK domain, quasi-static)
//   en_reg_out_15_8  output enables, outputs 15..8
//   en_reg_pwm_7_0   PWM-mode selects, outputs 7..0
//   en_reg_pwm_15_8  PWM-mode selects, outputs 15..8
//   pwm_duty_cycle   shared duty value 0x00..0xFF
//   out              registered user outputs
//   period_start     one-clock pulse on the first clock of each PWM period
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  // Layout of the config word: {en_pwm[15:0], en_out[15:0], duty[7:0]}
  logic [39:0] cfg_in;
  logic [39:0] cfg_p1, cfg_p2, cfg_p3;
  logic        vld_p1, vld_p2, vld_p3;
  logic        stable;

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic        tick;
  logic        bnd;
  logic        load_pending;
  logic        load;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  // Duty 0xFF is promoted to a full-period high instead of 255/256.
  function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] dc);
    if (dc == 8'hFF) return 1'b1;
    return cnt < dc;
  endfunction

  // A PWM-mode output follows the waveform; otherwise it is static high.
  // The output enable gates both cases.
  function automatic logic [15:0] drive(input logic [15:0] eo, input logic [15:0] ep,
                                        input logic hi);
    return eo & (~ep | {16{hi}});
  endfunction

  assign cfg_in = {en_reg_pwm_15_8, en_reg_pwm_7_0,
                   en_reg_out_15_8, en_reg_out_7_0, pwm_duty_cycle};

  // Stages p1/p2 form the synchroniser and p3 is a compare copy of p2.
  // The vld_pN flags track which stages hold post-reset samples. Without
  // them, the all-zero reset contents would look stable and get loaded
  // before the real configuration arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_p1 <= '0;
      cfg_p2 <= '0;
      cfg_p3 <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      cfg_p1 <= cfg_in;
      cfg_p2 <= cfg_p1;
      cfg_p3 <= cfg_p2;
      vld_p1 <= 1'b1;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  assign stable = vld_p3 && (cfg_p2 == cfg_p3);

  // Prescaler and period counter; these free-run and are never held off
  // by a deferred load.
  assign tick = (pre_cnt == PRE_MAX);
  assign bnd  = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // The shadow load happens at the boundary when the config is stable.
  // If the config is not stable then, the load retries every clock.
  assign load = (load_pending || bnd) && stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_pending <= 1'b1;
      en_out       <= '0;
      en_pwm       <= '0;
      duty         <= '0;
    end else begin
      if (load)     load_pending <= 1'b0;
      else if (bnd) load_pending <= 1'b1;
      if (load) begin
        en_pwm <= cfg_p2[39:24];
        en_out <= cfg_p2[23:8];
        duty   <= cfg_p2[7:0];
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= drive(en_out, en_pwm, pwm_level(pwm_cnt, duty));
      period_start <= bnd;
    end
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Output-drive stage directly downstream of the SPI register file. It consumes the five configuration bytes written over SPI (output enables, PWM enables, duty cycle) and drives the 16 user outputs, each either static high/low or modulated by a shared ~3 kHz, 8-bit-resolution PWM waveform. Configuration is resynchronised into the system clock domain and applied only at PWM period boundaries, so the outputs never glitch.

## Interface
- PRESCALE, 13: system clocks per PWM count step. PWM period = PRESCALE*256 clocks, 3328 at the default, ≈3.0 kHz at 10 MHz. Legal range 1..65535.
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, synchronous and active-high
- en_reg_out_7_0  in  8  output enable, outputs 7..0 (SCLK domain, quasi-static)
- en_reg_out_15_8  in  8  output enable, outputs 15..8
- en_reg_pwm_7_0  in  8  PWM-mode select, outputs 7..0
- en_reg_pwm_15_8  in  8  PWM-mode select, outputs 15..8
- pwm_duty_cycle  in  8  shared duty value, 0x00..0xFF
- out  out  16  registered user outputs
- period_start  out  1  one-clock pulse on the first clock of each PWM period

## Operation
- Config bus: the 40 input bits are concatenated into cfg_in.
  - cfg_in passes through two flop stages, s1 then s2.
  - A third stage s3 copies s2.
  - cfg is stable when s2 == s3.
- Prescaler pre_cnt runs 0..PRESCALE-1 and wraps. tick = (pre_cnt == PRESCALE-1).
- Period counter pwm_cnt is 8 bits. It increments on tick and wraps 255 → 0.
- Boundary: bnd = tick && pwm_cnt == 255.
- load_pending flag:
  - set by reset and by bnd;
  - cleared when a shadow load occurs.
- Shadow load: when load_pending (or bnd) && stable, the shadow registers take s2: en_out[15:0], en_pwm[15:0], duty[7:0].
  - If the config is not stable, the load is deferred clock by clock until it is.
  - Deferral never delays the counters.
- PWM level:
  - pwm_hi = 1 when duty == 0xFF.
  - Otherwise pwm_hi = (pwm_cnt < duty), an unsigned 8-bit compare.
  - duty 0x00 gives constant 0. duty 0xFF gives constant 1; 255/256 is not used.
- Per output i, the next value of out[i] = en_out[i] & (en_pwm[i] ? pwm_hi : 1'b1).
  - en_pwm set with en_out clear gives 0.
- period_start is registered. It is 1 on the clock following bnd, i.e. while pwm_cnt == 0 and pre_cnt == 0.

## Timing
- Reset, sampled on the clk edge while rst = 1:
  - out = 0, period_start = 0;
  - pre_cnt = 0, pwm_cnt = 0;
  - shadows = 0, s1/s2/s3 = 0;
  - load_pending = 1.
- Reset mid-period: outputs go to 0 on the next edge and counting restarts from 0. No partial-period state survives.
- Output latency: out reflects shadow state and pwm_cnt from the previous clock (1-cycle registered).
- Config latency:
  - Input change to s2: 2 clocks. Stable check: +1 clock.
  - Applied at the next boundary, or immediately after reset.
  - Visible on out 1 clock after the load.
  - Worst case ≈ 3 + PRESCALE*256 + 1 clocks.
- Duty change mid-period never affects the current period. The high time of each period always matches one duty value.
- A duty change at the same edge as bnd: the value in s2/s3 on that edge is the one used, provided it is stable; otherwise it is deferred as above.
- High time per period = duty*PRESCALE clocks for duty 1..254. duty 0xFF gives the full period.
- pwm_cnt wrap and shadow load happen on the same edge. The first clock of the new period uses the new shadow for the following out update.

## Test plan
- Reset: assert rst 3 clocks with all inputs 0xFF → out = 0x0000, period_start = 0. After release, out = 0xFFFF within 6 clocks.
- Static enable: en_reg_out_7_0 = 0x01, all others 0, through reset → out = 0x0001 within 6 clocks of release, and constant for 3 periods.
- 50% PWM: en_reg_out_7_0 = 0x01, en_reg_pwm_7_0 = 0x01, duty 0x80 → out[0] high 1664 / low 1664 clocks per 3328-clock period. period_start spacing = 3328.
- Extremes: duty 0x00 → out[0] constantly 0. duty 0xFF → constantly 1 across 2 full periods. en_pwm bit set with en_out clear → 0.
- Mid-period update: duty 0x40, then change to 0xC0 at pwm_cnt ≈ 100 → current period high 832 clocks; the next period high 2496 clocks. No short or extra pulse.
- Upper byte and reset mid-run: en_reg_out_15_8 = 0x80, en_reg_pwm_15_8 = 0x80, duty 0x10 → out[15] high 208 clocks per period. Assert rst at pwm_cnt = 150 → out = 0 next edge, and period_start resumes 3328 clocks after release.
